// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the block RAM controller.
package ram_pkg;

   // Controller states: accept a request, count down the access latency, present the response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Number of write-mask bits for a block (one per word).
   function automatic int mask_width(input int block_bits, input int word_bits);
      return block_bits / word_bits;
   endfunction

   // Width of a down-counter able to hold the value LATENCY.
   function automatic int cnt_width(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

   // Counter width for the default 50-cycle latency.
   localparam int LATENCY_DEFAULT = 50;
   localparam int CNT_W_DEFAULT   = $clog2(LATENCY_DEFAULT + 1);

endpackage

// File: rtl/ram_latency_timer.sv
// Loadable down-counter with a zero flag; times the access latency of one request.
module ram_latency_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] count_reg;

   // Load has priority; otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/block_ram_ctrl.sv
// Clocked block-wide main-memory model: one request at a time, masked writes,
// fixed access latency. Optional macro RAM_RANGE_CHECK_EN rejects addresses
// >= DEPTH with resp_err=1 instead of aliasing them modulo DEPTH.
// The storage array has no reset; its contents survive rst_n.
module block_ram_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_SIZE  = 24,
   parameter int BLOCK_BITS = 128,
   parameter int WORD_BITS  = 32,
   parameter int DEPTH      = 2 ** ADDR_SIZE,
   parameter int LATENCY    = 50
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [ADDR_SIZE-1:0]            req_addr,
   input  logic [BLOCK_BITS-1:0]           req_wdata,
   input  logic [BLOCK_BITS/WORD_BITS-1:0] req_wmask,
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic [BLOCK_BITS-1:0]           resp_rdata,
   output logic                            resp_err,
   output logic                            busy
);

   localparam int MASK_W = mask_width(BLOCK_BITS, WORD_BITS);
   localparam int CNT_W  = cnt_width(LATENCY);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

   state_t                  state_reg;
   logic                    we_reg;
   logic [ADDR_SIZE-1:0]    addr_reg;
   logic [BLOCK_BITS-1:0]   wdata_reg;
   logic [MASK_W-1:0]       wmask_reg;
   logic [BLOCK_BITS-1:0]   rdata_reg;
   logic                    err_reg;
   logic                    req_ready_reg;
   logic                    resp_valid_reg;
   logic                    busy_reg;

   logic [BLOCK_BITS-1:0]   mem_array [DEPTH];

   logic [IDX_W-1:0]        mem_idx;
   logic                    addr_oob;
   logic                    accept;
   logic                    commit;
   logic                    timer_zero;

   assign mem_idx = addr_reg[IDX_W-1:0];
   assign accept  = (state_reg == IDLE) && req_valid;
   assign commit  = (state_reg == WAIT) && timer_zero;

`ifdef RAM_RANGE_CHECK_EN
   localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE + 1)'(DEPTH);
   assign addr_oob = ({1'b0, addr_reg} >= DEPTH_EXT);
`else
   // High address bits only matter for range checking; here they alias away.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{1'b0, addr_reg};
   assign addr_oob = 1'b0;
`endif

   ram_latency_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (LOAD_VAL),
      .en       (state_reg == WAIT),
      .zero     (timer_zero)
   );

   // Commit the masked write on the last WAIT edge; the reset edge never commits.
   always_ff @(posedge clk) begin
      if (rst_n && commit && we_reg && !addr_oob) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (wmask_reg[i]) begin
               mem_array[mem_idx][i*WORD_BITS +: WORD_BITS] <= wdata_reg[i*WORD_BITS +: WORD_BITS];
            end
         end
      end
   end

   // Request/response FSM with registered handshake outputs and read capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wmask_reg      <= '0;
         rdata_reg      <= '0;
         err_reg        <= 1'b0;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  we_reg        <= req_we;
                  addr_reg      <= req_addr;
                  wdata_reg     <= req_wdata;
                  wmask_reg     <= req_wmask;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= WAIT;
               end
            end
            WAIT: begin
               if (timer_zero) begin
                  rdata_reg      <= (we_reg || addr_oob) ? '0 : mem_array[mem_idx];
                  err_reg        <= addr_oob;
                  resp_valid_reg <= 1'b1;
                  state_reg      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  rdata_reg      <= '0;
                  err_reg        <= 1'b0;
                  resp_valid_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  busy_reg       <= 1'b0;
                  state_reg      <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = rdata_reg;
   assign resp_err   = err_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_block_ram_ctrl.sv
// Directed bench for block_ram_ctrl: instance A (LATENCY=4, DEPTH=64) and
// instance B (LATENCY=1, DEPTH=16). Honours RAM_RANGE_CHECK_EN for the alias test.
module tb_block_ram_ctrl;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         a_req_valid, a_req_ready, a_req_we;
   logic [7:0]   a_req_addr;
   logic [127:0] a_req_wdata;
   logic [3:0]   a_req_wmask;
   logic         a_resp_valid, a_resp_ready, a_resp_err, a_busy;
   logic [127:0] a_resp_rdata;

   logic         b_req_valid, b_req_ready, b_req_we;
   logic [7:0]   b_req_addr;
   logic [127:0] b_req_wdata;
   logic [3:0]   b_req_wmask;
   logic         b_resp_valid, b_resp_ready, b_resp_err, b_busy;
   logic [127:0] b_resp_rdata;

   int checks   = 0;
   int failures = 0;

   block_ram_ctrl #(
      .ADDR_SIZE(8), .BLOCK_BITS(128), .WORD_BITS(32), .DEPTH(64), .LATENCY(LAT_A)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
   );

   block_ram_ctrl #(
      .ADDR_SIZE(8), .BLOCK_BITS(128), .WORD_BITS(32), .DEPTH(16), .LATENCY(LAT_B)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
   );

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_req_ready"}, 128'(a_req_ready), 128'd1);
      check_value({tag, "_resp_valid"}, 128'(a_resp_valid), 128'd0);
      check_value({tag, "_rdata"}, a_resp_rdata, 128'd0);
      check_value({tag, "_err"}, 128'(a_resp_err), 128'd0);
      check_value({tag, "_busy"}, 128'(a_busy), 128'd0);
   endtask

   // One request on instance A. edges = edges after the accepting edge until
   // resp_valid is seen; must equal LATENCY. During 'hold' cycles of
   // backpressure a stray write pulse is offered and must be ignored.
   task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                         input logic [127:0] wdata, input logic [3:0] wmask, input int hold,
                         output logic [127:0] rdata, output logic err);
      int edges;
      edges = 0;
      while (!a_req_ready && edges < 100) begin
         @(posedge clk); #1; edges++;
      end
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
      a_req_wdata = wdata; a_req_wmask = wmask;
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the controller must ignore them.
      a_req_valid = 1'b0; a_req_we = ~we; a_req_addr = addr ^ 8'h05;
      a_req_wdata = ~wdata; a_req_wmask = ~wmask;
      check_value({tag, "_busy"}, 128'(a_busy), 128'd1);
      edges = 0;
      while (!a_resp_valid && edges < 100) begin
         @(posedge clk); #1; edges++;
      end
      check_value({tag, "_lat"}, 128'(edges), 128'(LAT_A));
      rdata = a_resp_rdata;
      err   = a_resp_err;
      for (int h = 0; h < hold; h++) begin
         if (h == 3) begin
            a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr;
            a_req_wdata = '0; a_req_wmask = 4'hF;
         end else begin
            a_req_valid = 1'b0;
         end
         @(posedge clk); #1;
         check_value({tag, "_hold_data"}, a_resp_rdata, rdata);
         check_value({tag, "_hold_rdy"}, 128'(a_req_ready), 128'd0);
         check_value({tag, "_hold_vld"}, 128'(a_resp_valid), 128'd1);
      end
      a_req_valid  = 1'b0;
      a_resp_ready = 1'b1;
      @(posedge clk); #1;
      a_resp_ready = 1'b0;
      check_value({tag, "_done"}, 128'(a_resp_valid), 128'd0);
      $display("txn %s we=%0d addr=%h rdata=%h err=%0d lat=%0d", tag, we, addr, rdata, err, edges);
   endtask

   // Start a full-mask write on A, then reset so that the reset edge is
   // wait_edges+1 edges after acceptance.
   task automatic reset_during_write(input string tag, input logic [7:0] addr,
                                     input logic [127:0] wdata, input int wait_edges);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr;
      a_req_wdata = wdata; a_req_wmask = 4'hF;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      repeat (wait_edges) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs(tag);
      rst_n = 1'b1;
      repeat (LAT_A + 2) @(posedge clk);
      #1;
      check_value({tag, "_no_resp"}, 128'(a_resp_valid), 128'd0);
      $display("txn %s reset write addr=%h after %0d edges", tag, addr, wait_edges);
   endtask

   // Up to two requests on B with resp_ready held high; checks response
   // latency and that the second acceptance follows the first handshake.
   task automatic b_run(input string tag, input int n, input logic we,
                        input logic [7:0] addr0, input logic [7:0] addr1,
                        input logic [127:0] d0, input logic [127:0] d1,
                        output logic [127:0] r0, output logic [127:0] r1,
                        output logic e0, output logic e1);
      int acc_edge[2];
      int hs_edge[2];
      logic [127:0] rd[2];
      logic er[2];
      int na, nr;
      logic s_ready, s_rv, s_err;
      logic [127:0] s_data;
      acc_edge = '{0, 0}; hs_edge = '{0, 0}; rd = '{128'd0, 128'd0}; er = '{1'b0, 1'b0};
      na = 0; nr = 0;
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr0; b_req_wdata = d0;
      for (int k = 0; k < 12; k++) begin
         s_ready = b_req_ready; s_rv = b_resp_valid; s_data = b_resp_rdata; s_err = b_resp_err;
         @(posedge clk); #1;
         if (s_rv && nr < 2) begin
            hs_edge[nr] = k + 1; rd[nr] = s_data; er[nr] = s_err; nr++;
         end
         if (s_ready && b_req_valid && na < 2) begin
            acc_edge[na] = k + 1; na++;
            b_req_addr = addr1; b_req_wdata = d1;
            if (na == n) b_req_valid = 1'b0;
         end
      end
      b_req_valid = 1'b0;
      check_value({tag, "_count"}, 128'(nr), 128'(n));
      for (int i = 0; i < n; i++) begin
         // Response visible after edge hs_edge-1; must be LATENCY edges after acceptance.
         check_value({tag, "_lat"}, 128'(hs_edge[i] - 1 - acc_edge[i]), 128'(LAT_B));
      end
      if (n == 2) check_value({tag, "_gap"}, 128'(acc_edge[1]), 128'(hs_edge[0] + 1));
      r0 = rd[0]; r1 = rd[1]; e0 = er[0]; e1 = er[1];
      $display("txn %s n=%0d we=%0d addr=%h/%h r0=%h r1=%h", tag, n, we, addr0, addr1, r0, r1);
   endtask

   localparam logic [127:0] D10   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] ONES  = {128{1'b1}};
   localparam logic [127:0] P20   = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
   localparam logic [127:0] D30   = 128'h30303030_A5A5A5A5_5A5A5A5A_12345678;
   localparam logic [127:0] D31   = 128'h31313131_0F0F0F0F_F0F0F0F0_87654321;
   localparam logic [127:0] DNEW  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] DB1   = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] DB2   = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] DB3   = 128'hCAFEF00D_00000003_C0FFEE00_00000003;
   localparam logic [127:0] DB13  = 128'h13131313_13131313_13131313_13131313;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [127:0] r, r2;
      logic e, e2;
      rst_n = 1'b0;
      a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wmask = 0; a_resp_ready = 0;
      b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wmask = 4'hF; b_resp_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full write then readback.
      do_req("wr10", 1'b1, 8'h10, D10, 4'hF, 0, r, e);
      check_value("wr10_rdata", r, 128'd0);
      check_value("wr10_err", 128'(e), 128'd0);
      do_req("rd10", 1'b0, 8'h10, '0, 4'h0, 0, r, e);
      check_value("rd10_rdata", r, D10);
      check_value("rd10_err", 128'(e), 128'd0);

      // Partial write over all-ones.
      do_req("wr20a", 1'b1, 8'h20, ONES, 4'hF, 0, r, e);
      do_req("wr20b", 1'b1, 8'h20, '0, 4'b0101, 0, r, e);
      do_req("rd20", 1'b0, 8'h20, '0, 4'h0, 0, r, e);
      check_value("rd20_rdata", r, P20);

      // Backpressure with a stray write pulse, then confirm block untouched.
      do_req("rdbp", 1'b0, 8'h20, '0, 4'h0, 10, r, e);
      check_value("rdbp_rdata", r, P20);
      do_req("rd20b", 1'b0, 8'h20, '0, 4'h0, 0, r, e);
      check_value("rd20b_rdata", r, P20);

      // Reset mid-write and on the would-be commit edge.
      do_req("wr30", 1'b1, 8'h30, D30, 4'hF, 0, r, e);
      reset_during_write("rst30", 8'h30, DNEW, 2);
      do_req("rd30", 1'b0, 8'h30, '0, 4'h0, 0, r, e);
      check_value("rd30_rdata", r, D30);
      do_req("wr31", 1'b1, 8'h31, D31, 4'hF, 0, r, e);
      reset_during_write("rst31", 8'h31, DNEW, 3);
      do_req("rd31", 1'b0, 8'h31, '0, 4'h0, 0, r, e);
      check_value("rd31_rdata", r, D31);

      // LATENCY=1 back-to-back traffic on B.
      b_run("bwr12", 2, 1'b1, 8'h01, 8'h02, DB1, DB2, r, r2, e, e2);
      check_value("bwr12_r0", r, 128'd0);
      check_value("bwr12_r1", r2, 128'd0);
      b_run("brd12", 2, 1'b0, 8'h01, 8'h02, '0, '0, r, r2, e, e2);
      check_value("brd12_r0", r, DB1);
      check_value("brd12_r1", r2, DB2);

      // Address 0x13 against DEPTH=16.
      b_run("bwr03", 1, 1'b1, 8'h03, 8'h03, DB3, DB3, r, r2, e, e2);
      b_run("brd13", 1, 1'b0, 8'h13, 8'h13, '0, '0, r, r2, e, e2);
`ifdef RAM_RANGE_CHECK_EN
      check_value("brd13_rdata", r, 128'd0);
      check_value("brd13_err", 128'(e), 128'd1);
`else
      check_value("brd13_rdata", r, DB3);
      check_value("brd13_err", 128'(e), 128'd0);
`endif
      b_run("bwr13", 1, 1'b1, 8'h13, 8'h13, DB13, DB13, r, r2, e, e2);
      b_run("brd03", 1, 1'b0, 8'h03, 8'h03, '0, '0, r, r2, e, e2);
`ifdef RAM_RANGE_CHECK_EN
      check_value("brd03_rdata", r, DB3);
`else
      check_value("brd03_rdata", r, DB13);
`endif
      check_value("brd03_err", 128'(e), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
